multiplexador_escrita_pipeline: RTL and testbench

// Parametrised write-back source selector for the CPU datapath, successor to the fixed 6-way combinational mux.

---
 rtl/multiplexador_escrita_pipeline.sv | 151 +++++++++++++++
 tb/tb_multiplexador_escrita_pipeline.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multiplexador_escrita_pipeline.sv
// ---------------------------------------------------------------------------
// multiplexador_escrita_pipeline
//
// Write-back source selector for the CPU datapath. One of NUM_ENTRADAS
// sources is picked by sinalUC. The picked value is registered behind a
// 2-entry skid buffer with a valid/ready handshake. This lets a stall on the
// register-bank write port hold selected values without dropping or
// corrupting them.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   sinalUC     source select, sampled together with valido_in
//   entradas    flattened sources; source k = entradas[k*LARGURA +: LARGURA]
//   valido_in   upstream offers a selection this cycle
//   pronto_in   block can accept (registered: skid entry is empty)
//   saidaMUX    selected, registered data
//   valido_out  saidaMUX holds valid data
//   pronto_out  downstream accepts saidaMUX
//   erro_sel    sticky flag: an out-of-range select was accepted
//   ocupacao    number of entries held (0, 1 or 2)
// ---------------------------------------------------------------------------
module multiplexador_escrita_pipeline #(
    parameter int LARGURA        = 32,
    parameter int NUM_ENTRADAS   = 8,
    parameter int LARGURA_SEL    = 3,
    parameter int IDX_BUFFER     = 5,
    parameter int LARGURA_BUFFER = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [LARGURA_SEL-1:0]          sinalUC,
    input  logic [NUM_ENTRADAS*LARGURA-1:0] entradas,
    input  logic                            valido_in,
    output logic                            pronto_in,
    output logic [LARGURA-1:0]              saidaMUX,
    output logic                            valido_out,
    input  logic                            pronto_out,
    output logic                            erro_sel,
    output logic [1:0]                      ocupacao
);

    // Keeps only the low LARGURA_BUFFER bits of the buffer channel.
    localparam logic [LARGURA-1:0] MASCARA_BUFFER =
        {LARGURA{1'b1}} >> (LARGURA - LARGURA_BUFFER);

    typedef enum logic [1:0] {
        VAZIO  = 2'd0,
        CHEIO1 = 2'd1,
        CHEIO2 = 2'd2
    } estado_t;

    estado_t              estado_q;
    logic [LARGURA-1:0]   saida_q;
    logic [LARGURA-1:0]   skid_q;
    logic                 valido_q;
    logic                 pronto_q;
    logic                 erro_q;
    logic [1:0]           ocupacao_q;

    logic [LARGURA-1:0]   dado_sel_d;
    logic                 sel_ok;
    logic                 aceita;
    logic                 entrega;

    // Select function. An out-of-range select yields zero data, never X.
    always_comb begin
        // NOTE: defaults first so that every path assigns and no latch is inferred.
        dado_sel_d = '0;
        sel_ok     = 1'b0;
        for (int k = 0; k < NUM_ENTRADAS; k++) begin
            if (sinalUC == LARGURA_SEL'(k)) begin
                sel_ok = 1'b1;
                if (k == IDX_BUFFER)
                    dado_sel_d = entradas[k*LARGURA +: LARGURA] & MASCARA_BUFFER;
                else
                    dado_sel_d = entradas[k*LARGURA +: LARGURA];
            end
        end
    end

    assign aceita  = valido_in && pronto_q;
    assign entrega = valido_q && pronto_out;

    // Handshake FSM. Every output is a flop, so pronto_in has no
    // combinational path from pronto_out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= VAZIO;
            saida_q    <= '0;
            // NOTE: the skid entry is reset too, so no stale data can surface after a mid-transfer reset.
            skid_q     <= '0;
            valido_q   <= 1'b0;
            pronto_q   <= 1'b1;
            erro_q     <= 1'b0;
            ocupacao_q <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments throughout, so all state updates together on the edge.
            if (aceita && !sel_ok)
                erro_q <= 1'b1;

            case (estado_q)
                VAZIO: begin
                    if (aceita) begin
                        saida_q    <= dado_sel_d;
                        valido_q   <= 1'b1;
                        ocupacao_q <= 2'd1;
                        estado_q   <= CHEIO1;
                    end
                end
                CHEIO1: begin
                    if (aceita && entrega) begin
                        saida_q <= dado_sel_d;
                    end else if (aceita) begin
                        // Output stalled: park the new value in the skid entry.
                        skid_q     <= dado_sel_d;
                        pronto_q   <= 1'b0;
                        ocupacao_q <= 2'd2;
                        estado_q   <= CHEIO2;
                    end else if (entrega) begin
                        valido_q   <= 1'b0;
                        ocupacao_q <= 2'd0;
                        estado_q   <= VAZIO;
                    end
                end
                CHEIO2: begin
                    if (entrega) begin
                        saida_q    <= skid_q;
                        skid_q     <= '0;
                        pronto_q   <= 1'b1;
                        ocupacao_q <= 2'd1;
                        estado_q   <= CHEIO1;
                    end
                end
                default: begin
                    estado_q   <= VAZIO;
                    valido_q   <= 1'b0;
                    pronto_q   <= 1'b1;
                    ocupacao_q <= 2'd0;
                end
            endcase
        end
    end

    assign saidaMUX   = saida_q;
    assign valido_out = valido_q;
    assign pronto_in  = pronto_q;
    assign erro_sel   = erro_q;
    assign ocupacao   = ocupacao_q;

endmodule

// File: tb/tb_multiplexador_escrita_pipeline.sv
// ---------------------------------------------------------------------------
// Testbench for multiplexador_escrita_pipeline (6 sources, buffer channel 5).
// A queue model tracks the accepted-but-undelivered values. A negedge process
// compares the DUT outputs with it every cycle. Directed sequences add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_multiplexador_escrita_pipeline;

    localparam int L   = 32;
    localparam int N   = 6;
    localparam int SW  = 3;
    localparam int IB  = 5;
    localparam int LB  = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [SW-1:0]   sinalUC = '0;
    logic [N*L-1:0]  entradas = '0;
    logic            valido_in = 1'b0;
    logic            pronto_in;
    logic [L-1:0]    saidaMUX;
    logic            valido_out;
    logic            pronto_out = 1'b0;
    logic            erro_sel;
    logic [1:0]      ocupacao;

    int total = 0;
    int bad   = 0;

    multiplexador_escrita_pipeline #(
        .LARGURA(L), .NUM_ENTRADAS(N), .LARGURA_SEL(SW),
        .IDX_BUFFER(IB), .LARGURA_BUFFER(LB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sinalUC    (sinalUC),
        .entradas   (entradas),
        .valido_in  (valido_in),
        .pronto_in  (pronto_in),
        .saidaMUX   (saidaMUX),
        .valido_out (valido_out),
        .pronto_out (pronto_out),
        .erro_sel   (erro_sel),
        .ocupacao   (ocupacao)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", nome, got, exp, $time);
        end
    endtask

    // Value the specification says a given select produces.
    function automatic logic [31:0] esperado(input logic [SW-1:0] s, input logic [N*L-1:0] e);
        int idx;
        idx = int'(s);
        if (idx >= N)  return 32'h0;
        if (idx == IB) return {24'h0, e[idx*L +: LB]};
        return e[idx*L +: L];
    endfunction

    // Model: in-order queue of accepted values plus sticky error flag.
    logic [31:0] fila[$];
    logic        erro_m = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            fila.delete();
            erro_m = 1'b0;
        end else begin
            bit acc, dlv;
            acc = valido_in && (fila.size() < 2);
            dlv = (fila.size() > 0) && pronto_out;
            if (dlv) void'(fila.pop_front());
            if (acc) begin
                fila.push_back(esperado(sinalUC, entradas));
                if (int'(sinalUC) >= N) erro_m = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("ocupacao", 32'(ocupacao), 32'(fila.size()));
            check("valido_out", 32'(valido_out), 32'(fila.size() > 0));
            check("pronto_in", 32'(pronto_in), 32'(fila.size() < 2));
            check("erro_sel", 32'(erro_sel), 32'(erro_m));
            if (fila.size() > 0)
                check("saidaMUX", saidaMUX, fila[0]);
        end
    end

    task automatic fontes_padrao();
        for (int k = 0; k < N; k++)
            entradas[k*L +: L] = 32'h1000 + 32'(k);
    endtask

    // Called at a negedge: drive inputs, then advance to the next negedge.
    task automatic ciclo(input logic v, input logic [SW-1:0] s, input logic po);
        valido_in  = v;
        sinalUC    = s;
        pronto_out = po;
        @(negedge clock);
    endtask

    initial begin
        fontes_padrao();
        repeat (2) @(negedge clock);
        check("reset_valido_out", 32'(valido_out), 32'h0);
        check("reset_pronto_in", 32'(pronto_in), 32'h1);
        check("reset_saida", saidaMUX, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // T2 streaming
        ciclo(1'b1, 3'd0, 1'b1); check("t2_s0", saidaMUX, 32'h1000);
        ciclo(1'b1, 3'd2, 1'b1); check("t2_s2", saidaMUX, 32'h1002);
        check("t2_occ", 32'(ocupacao), 32'd1);
        ciclo(1'b1, 3'd4, 1'b1); check("t2_s4", saidaMUX, 32'h1004);
        ciclo(1'b0, 3'd0, 1'b1); check("t2_drain", 32'(valido_out), 32'h0);

        // T3 stall; an out-of-range select offered while full must be ignored
        ciclo(1'b1, 3'd1, 1'b0); check("t3_s1", saidaMUX, 32'h1001);
        ciclo(1'b1, 3'd3, 1'b0); check("t3_occ2", 32'(ocupacao), 32'd2);
        check("t3_pronto0", 32'(pronto_in), 32'h0);
        ciclo(1'b1, 3'd7, 1'b0); check("t3_hold", saidaMUX, 32'h1001);
        check("t3_no_err", 32'(erro_sel), 32'h0);
        ciclo(1'b0, 3'd0, 1'b1); check("t3_s3", saidaMUX, 32'h1003);
        check("t3_occ1", 32'(ocupacao), 32'd1);
        ciclo(1'b0, 3'd0, 1'b1); check("t3_empty", 32'(ocupacao), 32'd0);

        // T4 buffer zero-extend
        entradas[5*L +: L] = 32'hDEADBEEF;
        ciclo(1'b1, 3'd5, 1'b0); check("t4_buf", saidaMUX, 32'h000000EF);
        ciclo(1'b0, 3'd0, 1'b1);
        fontes_padrao();

        // T5 bad selects (6 and 7) -> zero data, sticky error
        ciclo(1'b1, 3'd7, 1'b0); check("t5_zero", saidaMUX, 32'h0);
        check("t5_err", 32'(erro_sel), 32'h1);
        ciclo(1'b1, 3'd0, 1'b1); check("t5_next", saidaMUX, 32'h1000);
        ciclo(1'b1, 3'd6, 1'b1); check("t5_zero6", saidaMUX, 32'h0);
        ciclo(1'b0, 3'd0, 1'b1); check("t5_sticky", 32'(erro_sel), 32'h1);

        // T1 reset while two entries are held
        ciclo(1'b1, 3'd1, 1'b0);
        ciclo(1'b1, 3'd2, 1'b0);
        check("t1_pre_occ", 32'(ocupacao), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("t1_saida", saidaMUX, 32'h0);
        check("t1_valido", 32'(valido_out), 32'h0);
        check("t1_occ", 32'(ocupacao), 32'd0);
        check("t1_pronto", 32'(pronto_in), 32'h1);
        check("t1_err", 32'(erro_sel), 32'h0);
        valido_in = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        ciclo(1'b0, 3'd0, 1'b1); check("t1_no_dlv", 32'(valido_out), 32'h0);
        ciclo(1'b0, 3'd0, 1'b1);

        // T6 random traffic checked by the model
        for (int i = 0; i < 10000; i++) begin
            for (int k = 0; k < N; k++)
                entradas[k*L +: L] = $urandom;
            ciclo(($urandom_range(0, 3) != 0), SW'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) != 0));
        end
        ciclo(1'b0, 3'd0, 1'b1);
        ciclo(1'b0, 3'd0, 1'b1);
        ciclo(1'b0, 3'd0, 1'b1);
        check("t6_final_empty", 32'(ocupacao), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
